gp_cmd_executor: RTL and testbench
==================================

// Module: gp_cmd_executor
// PURPOSE
//  Command-execution engine for the GP engine; consumes the command buffer from its FSM side.
//  Fetches 64-bit entries by word address and decodes {addr[63:34], data[33:2], type[1:0]}.
//  Executes WRITE and read-modify-write (RWM) sequences as bus transactions on an AHB-Lite master port.
//  Reports busy/done/error to the GP engine control logic.
// PARAMETERS
//  CMD_WIDTH   64         command entry width
//  ADDR_WIDTH  32         command/bus address width
//  DATA_WIDTH  32         bus data width
//  END_ADDR    32'h4A0    first command address past the buffer; fetch never reaches it
// PORTS
//  clk            in   1    clock
//  rst            in   1    asynchronous active-high reset
//  start          in   1    pulse: execute the command list from address 0
//  busy           out  1    high from start acceptance until done/err
//  done           out  1    one-cycle pulse on normal completion
//  err            out  1    sticky sequence/decode error; cleared by next accepted start
//  cmd_cnt        out  16   commands completed in current/last run
//  cmd_rd_en      out  1    one-cycle fetch request to the command buffer
//  cmd_addr       out  32   fetch address (step 4)
//  cmd_rd_valid   in   1    cmd_out valid (one cycle after cmd_rd_en)
//  cmd_out        in   64   fetched entry
//  mst_o_valid    out  1    bus request valid
//  mst_o_addr     out  32   bus address {cmd[63:34],2'b00}
//  mst_o_wr_data  out  32   bus write data
//  mst_o_rd0_wr1  out  1    1 = write, 0 = read
//  mst_i_ready    in   1    slave accepts request when valid && ready
//  mst_i_rd_data  in   32   read data
//  mst_i_rd_valid in   1    read data valid
// BEHAVIOUR
//  Reset (any state, immediate): state IDLE; all outputs 0; cmd_addr = 0; in-flight bus request dropped.
//  Type encoding: 2'b00 WRITE, 2'b01 RWM; 2'b10/2'b11 illegal -> ERR.
//  End of list: fetched entry all-zero, or cmd_addr reaches END_ADDR -> DONE.
//  FSM states:
//   IDLE: start -> FETCH; cmd_addr = 0, cmd_cnt = 0, err = 0, busy = 1.
//   FETCH: cmd_rd_en = 1 for exactly one cycle -> WAIT_CMD.
//   WAIT_CMD: hold until cmd_rd_valid; latch entry.
//     All-zero entry -> DONE.
//     WRITE -> ISSUE_WR, write data = cmd[33:2].
//     RWM -> ISSUE_RD; latch address A and mask M = cmd[33:2].
//     Illegal type -> ERR.
//   ISSUE_RD: mst_o_valid = 1, rd0_wr1 = 0, addr = A; on ready -> WAIT_RD.
//   WAIT_RD: on mst_i_rd_valid, latch R; cmd_addr += 4 -> FETCH2 (or ERR if cmd_addr + 4 = END_ADDR).
//   FETCH2 / WAIT_CMD2: fetch the partner entry; the partner's address field is ignored.
//     Partner type != WRITE -> ERR.
//     Otherwise write data = (R & ~M) | (V & M), with V = partner data -> ISSUE_WR to A.
//   ISSUE_WR: mst_o_valid = 1, rd0_wr1 = 1; on ready -> NEXT. RWM counts as one command.
//   NEXT: cmd_cnt++; cmd_addr += 4.
//     cmd_addr + 4 == END_ADDR -> DONE; else -> FETCH.
//   DONE: done = 1 for one cycle, busy = 0 -> IDLE.
//   ERR: err = 1 (sticky), busy = 0 -> IDLE. No further bus traffic.
//  Handshake: mst_o_* held stable while valid && !ready; valid drops the cycle after acceptance.
//   No back-to-back requests without an intervening FSM state.
//  start while busy: ignored. start coincident with done: ignored (IDLE entered next cycle).
//  Best case: a WRITE command takes 4 cycles from fetch to NEXT (FETCH, WAIT_CMD, ISSUE_WR w/ ready, NEXT).
// TESTING
//  1. Entries 0: {A=0x100,D=0xAA,WRITE}, 4: zero; start -> one write 0x100=0xAA; cmd_cnt = 1, done pulse, err = 0.
//  2. Entries RWM(A=0x200,M=0x0F), WRITE(V=0x05); bus read returns 0xF3 -> write 0x200=0xF5; cmd_cnt = 1.
//  3. Entries RWM, then RWM partner -> err = 1, busy = 0, no bus write issued.
//  4. mst_i_ready low 5 cycles during ISSUE_WR -> addr/data/valid stable all 5 cycles; single accepted write.
//  5. Buffer full of 296 WRITE entries -> stops at cmd_addr 0x49C; cmd_cnt = 296, done.
//  6. rst asserted in WAIT_RD -> all outputs 0 immediately; next start runs cleanly from address 0.

Source files
------------

// File: rtl/gp_cmd_executor_if.sv
// Command-buffer fetch port and AHB-Lite style master port of the GP command executor.
// The executor uses the master modport; the buffer and bus slave use the slave modport.
interface gp_cmd_executor_if #(
    parameter int CMD_WIDTH  = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_rd_en;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_rd_valid;
    logic [CMD_WIDTH-1:0]  cmd_out;

    logic                  mst_o_valid;
    logic [ADDR_WIDTH-1:0] mst_o_addr;
    logic [DATA_WIDTH-1:0] mst_o_wr_data;
    logic                  mst_o_rd0_wr1;
    logic                  mst_i_ready;
    logic [DATA_WIDTH-1:0] mst_i_rd_data;
    logic                  mst_i_rd_valid;

    modport master (
        output cmd_rd_en, cmd_addr,
        input  cmd_rd_valid, cmd_out,
        output mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1,
        input  mst_i_ready, mst_i_rd_data, mst_i_rd_valid
    );

    modport slave (
        input  cmd_rd_en, cmd_addr,
        output cmd_rd_valid, cmd_out,
        input  mst_o_valid, mst_o_addr, mst_o_wr_data, mst_o_rd0_wr1,
        output mst_i_ready, mst_i_rd_data, mst_i_rd_valid
    );
endinterface

// File: rtl/gp_cmd_executor.sv
// GP engine command executor: walks the command buffer from address 0 and turns WRITE and
// read-modify-write entries into bus transactions, reporting busy/done/err.
module gp_cmd_executor #(
    parameter int                    CMD_WIDTH  = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 32'h4A0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       cmd_cnt,
    gp_cmd_executor_if.master bus
);
    localparam int AF_W = CMD_WIDTH - DATA_WIDTH - 2;
    localparam logic [1:0] TYPE_WRITE = 2'b00;
    localparam logic [1:0] TYPE_RWM   = 2'b01;

    typedef enum logic [3:0] {
        IDLE, FETCH, WAIT_CMD, ISSUE_RD, WAIT_RD,
        FETCH2, WAIT_CMD2, ISSUE_WR, NEXT, DONE, ERR
    } state_t;

    state_t                state_reg,    state_next;
    logic [ADDR_WIDTH-1:0] cmd_addr_reg, cmd_addr_next;
    logic [15:0]           cmd_cnt_reg,  cmd_cnt_next;
    logic                  err_reg,      err_next;
    logic [AF_W-1:0]       addr_reg,     addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg,    wdata_next;
    logic [DATA_WIDTH-1:0] mask_reg,     mask_next;
    logic [DATA_WIDTH-1:0] rdata_reg,    rdata_next;

    logic [1:0]            ent_type;
    logic [DATA_WIDTH-1:0] ent_data;
    logic [AF_W-1:0]       ent_addr;
    logic [DATA_WIDTH-1:0] merged;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic                  last_entry;
    logic                  rd_en_c, valid_c, wr_c, busy_c, done_c;

    assign ent_type   = bus.cmd_out[1:0];
    assign ent_data   = bus.cmd_out[DATA_WIDTH+1:2];
    assign ent_addr   = bus.cmd_out[CMD_WIDTH-1:DATA_WIDTH+2];
    assign step_addr  = cmd_addr_reg + ADDR_WIDTH'(4);
    assign last_entry = (step_addr == END_ADDR);

    // RWM merge: masked bits come from the partner entry, the rest from the read-back value.
    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_merge
            assign merged[gi] = mask_reg[gi] ? ent_data[gi] : rdata_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cmd_addr_reg <= '0;
            cmd_cnt_reg  <= '0;
            err_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            mask_reg     <= '0;
            rdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            cmd_addr_reg <= cmd_addr_next;
            cmd_cnt_reg  <= cmd_cnt_next;
            err_reg      <= err_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            mask_reg     <= mask_next;
            rdata_reg    <= rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cmd_addr_next = cmd_addr_reg;
        cmd_cnt_next  = cmd_cnt_reg;
        err_next      = err_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        mask_next     = mask_reg;
        rdata_next    = rdata_reg;
        rd_en_c       = 1'b0;
        valid_c       = 1'b0;
        wr_c          = 1'b0;
        busy_c        = 1'b1;
        done_c        = 1'b0;

        unique case (state_reg)
            IDLE: begin
                busy_c = 1'b0;
                if (start) begin
                    state_next    = FETCH;
                    cmd_addr_next = '0;
                    cmd_cnt_next  = '0;
                    err_next      = 1'b0;
                end
            end
            FETCH: begin
                rd_en_c    = 1'b1;
                state_next = WAIT_CMD;
            end
            WAIT_CMD: begin
                if (bus.cmd_rd_valid) begin
                    if (bus.cmd_out == '0) begin
                        state_next = DONE;
                    end else if (ent_type == TYPE_WRITE) begin
                        addr_next  = ent_addr;
                        wdata_next = ent_data;
                        state_next = ISSUE_WR;
                    end else if (ent_type == TYPE_RWM) begin
                        addr_next  = ent_addr;
                        mask_next  = ent_data;
                        state_next = ISSUE_RD;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end
                end
            end
            ISSUE_RD: begin
                valid_c = 1'b1;
                if (bus.mst_i_ready) state_next = WAIT_RD;
            end
            WAIT_RD: begin
                if (bus.mst_i_rd_valid) begin
                    rdata_next = bus.mst_i_rd_data;
                    // An RWM in the last slot has no partner entry to fetch.
                    if (last_entry) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else begin
                        cmd_addr_next = step_addr;
                        state_next    = FETCH2;
                    end
                end
            end
            FETCH2: begin
                rd_en_c    = 1'b1;
                state_next = WAIT_CMD2;
            end
            WAIT_CMD2: begin
                if (bus.cmd_rd_valid) begin
                    if (ent_type != TYPE_WRITE) begin
                        err_next   = 1'b1;
                        state_next = ERR;
                    end else begin
                        wdata_next = merged;
                        state_next = ISSUE_WR;
                    end
                end
            end
            ISSUE_WR: begin
                valid_c = 1'b1;
                wr_c    = 1'b1;
                if (bus.mst_i_ready) state_next = NEXT;
            end
            NEXT: begin
                cmd_cnt_next = cmd_cnt_reg + 16'd1;
                if (last_entry) begin
                    state_next = DONE;
                end else begin
                    cmd_addr_next = step_addr;
                    state_next    = FETCH;
                end
            end
            DONE: begin
                busy_c     = 1'b0;
                done_c     = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                busy_c     = 1'b0;
                state_next = IDLE;
            end
            default: begin
                busy_c     = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign busy              = busy_c;
    assign done              = done_c;
    assign err               = err_reg;
    assign cmd_cnt           = cmd_cnt_reg;
    assign bus.cmd_rd_en     = rd_en_c;
    assign bus.cmd_addr      = cmd_addr_reg;
    assign bus.mst_o_valid   = valid_c;
    assign bus.mst_o_rd0_wr1 = wr_c;
    assign bus.mst_o_addr    = {addr_reg, 2'b00};
    assign bus.mst_o_wr_data = wdata_reg;
endmodule

// File: tb/tb_gp_cmd_executor.sv
// Directed bench for gp_cmd_executor: command-buffer and bus-slave models plus a scoreboard
// of expected bus reads/writes checked with immediate assertions.
`timescale 1ns/1ps
module tb_gp_cmd_executor;
    localparam logic [31:0] END_ADDR = 32'h4A0;
    localparam int          N_ENT    = 296;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [15:0] cmd_cnt;

    gp_cmd_executor_if bus_if ();

    gp_cmd_executor #(.END_ADDR(END_ADDR)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .cmd_cnt (cmd_cnt),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [N_ENT];
    logic [63:0] wr_q [$];
    logic [31:0] rd_q [$];
    int          checks = 0;
    int          fails  = 0;
    int          stall_left = 0;
    bit          hold_rd = 1'b0;
    logic [31:0] rd_return = '0;
    int          wr_acc = 0, rd_acc = 0, done_seen = 0, bad_fetch = 0;
    bit          cmd_pend = 1'b0, rd_pend = 1'b0;
    logic [63:0] cmd_data_pend = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic [31:0] a, input logic [31:0] d, input logic [1:0] t);
        return {a[31:2], d, t};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < N_ENT; i++) mem[i] = '0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int maxc, output int cyc);
        bit reached;
        reached = 1'b0;
        cyc = 0;
        while (!reached && cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (done || err) reached = 1'b1;
        end
        check({tag, "_end_reached"}, 64'(reached), 64'd1);
    endtask

    // Command buffer and bus slave, evaluated on the falling edge.
    initial begin
        bus_if.cmd_rd_valid   = 1'b0;
        bus_if.cmd_out        = '0;
        bus_if.mst_i_ready    = 1'b0;
        bus_if.mst_i_rd_data  = '0;
        bus_if.mst_i_rd_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cmd_pend              = 1'b0;
                rd_pend               = 1'b0;
                bus_if.cmd_rd_valid   = 1'b0;
                bus_if.cmd_out        = '0;
                bus_if.mst_i_ready    = 1'b0;
                bus_if.mst_i_rd_data  = '0;
                bus_if.mst_i_rd_valid = 1'b0;
            end else begin
                bus_if.cmd_rd_valid   = cmd_pend;
                bus_if.cmd_out        = cmd_pend ? cmd_data_pend : 64'd0;
                bus_if.mst_i_rd_valid = rd_pend;
                bus_if.mst_i_rd_data  = rd_pend ? rd_return : 32'd0;
                cmd_pend = bus_if.cmd_rd_en;
                if (bus_if.cmd_rd_en) begin
                    if (bus_if.cmd_addr < END_ADDR) begin
                        cmd_data_pend = mem[int'(bus_if.cmd_addr >> 2)];
                    end else begin
                        cmd_data_pend = '0;
                        bad_fetch++;
                    end
                end
                rd_pend = 1'b0;
                if (done) done_seen++;
                if (bus_if.mst_o_valid && bus_if.mst_o_rd0_wr1 && stall_left > 0) begin
                    bus_if.mst_i_ready = 1'b0;
                    stall_left--;
                    check("stall_q_nonempty", 64'(wr_q.size() != 0), 64'd1);
                    if (wr_q.size() != 0)
                        check("stall_hold", {bus_if.mst_o_addr, bus_if.mst_o_wr_data}, wr_q[0]);
                end else begin
                    bus_if.mst_i_ready = 1'b1;
                end
                if (bus_if.mst_o_valid && bus_if.mst_i_ready) begin
                    if (bus_if.mst_o_rd0_wr1) begin
                        wr_acc++;
                        check("wr_expected", 64'(wr_q.size() != 0), 64'd1);
                        if (wr_q.size() != 0)
                            check("wr_addr_data", {bus_if.mst_o_addr, bus_if.mst_o_wr_data}, wr_q.pop_front());
                        $display("bus write addr=%08h data=%08h", bus_if.mst_o_addr, bus_if.mst_o_wr_data);
                    end else begin
                        rd_acc++;
                        check("rd_expected", 64'(rd_q.size() != 0), 64'd1);
                        if (rd_q.size() != 0)
                            check("rd_addr", 64'(bus_if.mst_o_addr), 64'(rd_q.pop_front()));
                        $display("bus read  addr=%08h", bus_if.mst_o_addr);
                        rd_pend = !hold_rd;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, w0, d0, r0;
        clear_mem();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              64'({busy, done, err, cmd_cnt, bus_if.cmd_rd_en, bus_if.cmd_addr, bus_if.mst_o_valid}),
              64'd0);

        // 1: single WRITE then end-of-list
        mem[0] = ent(32'h100, 32'hAA, 2'b00);
        wr_q.push_back({32'h100, 32'hAA});
        w0 = wr_acc;
        pulse_start();
        wait_end("t1", 50, cyc);
        check("t1_done", 64'(done), 64'd1);
        check("t1_latency", 64'(cyc), 64'd6);
        check("t1_cnt", 64'(cmd_cnt), 64'd1);
        check("t1_err_busy", 64'({err, busy}), 64'd0);
        check("t1_writes", 64'(wr_acc - w0), 64'd1);

        // 2: RWM with partner WRITE
        clear_mem();
        mem[0] = ent(32'h200, 32'h0F, 2'b01);
        mem[1] = ent(32'h3FC, 32'h05, 2'b00);
        rd_return = 32'hF3;
        rd_q.push_back(32'h200);
        wr_q.push_back({32'h200, 32'hF5});
        w0 = wr_acc;
        pulse_start();
        wait_end("t2", 50, cyc);
        check("t2_done", 64'(done), 64'd1);
        check("t2_cnt", 64'(cmd_cnt), 64'd1);
        check("t2_writes", 64'(wr_acc - w0), 64'd1);
        check("t2_err", 64'(err), 64'd0);

        // 3: RWM followed by RWM partner -> error, no write
        clear_mem();
        mem[0] = ent(32'h240, 32'hFF, 2'b01);
        mem[1] = ent(32'h0, 32'h1, 2'b01);
        rd_q.push_back(32'h240);
        w0 = wr_acc;
        d0 = done_seen;
        pulse_start();
        wait_end("t3", 50, cyc);
        check("t3_err_busy", 64'({err, busy}), 64'b10);
        repeat (3) @(negedge clk);
        check("t3_err_sticky", 64'(err), 64'd1);
        check("t3_no_write", 64'(wr_acc - w0), 64'd0);
        check("t3_no_done", 64'(done_seen - d0), 64'd0);
        check("t3_rd_q_empty", 64'(rd_q.size()), 64'd0);

        // 4: write held off by 5 stall cycles
        clear_mem();
        mem[0] = ent(32'h300, 32'h12345678, 2'b00);
        wr_q.push_back({32'h300, 32'h12345678});
        w0 = wr_acc;
        stall_left = 5;
        pulse_start();
        wait_end("t4", 50, cyc);
        check("t4_stalls_used", 64'(stall_left), 64'd0);
        check("t4_writes", 64'(wr_acc - w0), 64'd1);
        check("t4_cnt_err", 64'({err, cmd_cnt}), 64'd1);

        // 5: full buffer of WRITE entries
        for (int i = 0; i < N_ENT; i++) begin
            mem[i] = ent(32'h1000 + 32'(4 * i), 32'hA500_0000 + 32'(i), 2'b00);
            wr_q.push_back({32'h1000 + 32'(4 * i), 32'hA500_0000 + 32'(i)});
        end
        w0 = wr_acc;
        pulse_start();
        wait_end("t5", 2000, cyc);
        check("t5_done", 64'(done), 64'd1);
        check("t5_cnt", 64'(cmd_cnt), 64'd296);
        check("t5_addr", 64'(bus_if.cmd_addr), 64'h49C);
        check("t5_writes", 64'(wr_acc - w0), 64'd296);
        check("t5_no_bad_fetch", 64'(bad_fetch), 64'd0);

        // 6: reset while waiting for read data
        clear_mem();
        mem[0] = ent(32'h500, 32'h11, 2'b00);
        mem[1] = ent(32'h600, 32'hF0, 2'b01);
        mem[2] = ent(32'h0, 32'h0A, 2'b00);
        wr_q.push_back({32'h500, 32'h11});
        rd_q.push_back(32'h600);
        hold_rd = 1'b1;
        r0 = rd_acc;
        pulse_start();
        cyc = 0;
        while (rd_acc == r0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_read_seen", 64'(rd_acc - r0), 64'd1);
        repeat (2) @(negedge clk);
        check("t6_pre_rst", 64'({busy, cmd_cnt, bus_if.cmd_addr}), {31'd0, 1'b1, 16'd1, 32'd4});
        #2 rst = 1'b1;
        #1;
        check("t6_rst_outputs",
              {busy, done, err, bus_if.cmd_rd_en, bus_if.mst_o_valid, bus_if.mst_o_rd0_wr1,
               cmd_cnt, bus_if.cmd_addr[9:0], bus_if.mst_o_addr[15:0], bus_if.mst_o_wr_data[15:0]},
              64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hold_rd = 1'b0;
        clear_mem();
        mem[0] = ent(32'h700, 32'h77, 2'b00);
        wr_q.push_back({32'h700, 32'h77});
        w0 = wr_acc;
        pulse_start();
        wait_end("t6", 50, cyc);
        check("t6_done", 64'(done), 64'd1);
        check("t6_cnt_err", 64'({err, cmd_cnt}), 64'd1);
        check("t6_writes", 64'(wr_acc - w0), 64'd1);
        check("t6_queues_empty", 64'(wr_q.size() + rd_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
